// File: rtl/bram_delay_prog_if.sv
// bram_delay_prog_if: sample/control bundle for the programmable delay line.
// master drives ce/delay/delay_load/din; slave returns dout/dout_valid/delay_cur.
interface bram_delay_prog_if #(
  parameter int WIDTH     = 128,
  parameter int DLY_WIDTH = 11
);
  logic                 ce;
  logic [DLY_WIDTH-1:0] delay;
  logic                 delay_load;
  logic [WIDTH-1:0]     din;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic [DLY_WIDTH-1:0] delay_cur;

  modport master (
    output ce, delay, delay_load, din,
    input  dout, dout_valid, delay_cur
  );

  modport slave (
    input  ce, delay, delay_load, din,
    output dout, dout_valid, delay_cur
  );
endinterface

// File: rtl/bram_delay_prog.sv
// bram_delay_prog: run-time programmable ce-gated delay line on a circular BRAM.
// Ports: clk, rst_n (async low), bus (slave): ce, delay, delay_load, din -> dout, dout_valid, delay_cur.
module bram_delay_prog #(
  parameter int    WIDTH         = 128,
  parameter int    MAX_DELAY     = 1024,
  parameter int    LATENCY       = 2,
  parameter string TARGET_DEVICE = "VIRTEX5",
  localparam int   ADDR_WIDTH    = ($clog2(MAX_DELAY) > 9) ? $clog2(MAX_DELAY) : 9,
  localparam int   DLY_WIDTH     = $clog2(MAX_DELAY + 1)
) (
  input logic              clk,
  input logic              rst_n,
  bram_delay_prog_if.slave bus
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int MIN_DELAY = LATENCY + 1;
  // Virtex-6 packs into 18Kb halves, Virtex-5 into full 36Kb blocks.
  localparam int BLK_BITS  = (TARGET_DEVICE == "VIRTEX6") ? 18432 : 36864;
  localparam int IO_RAW    = BLK_BITS / DEPTH;
  localparam int IO_WIDTH  = (IO_RAW > 72) ? 72 : ((IO_RAW < 1) ? 1 : IO_RAW);
  localparam int N_COL     = (WIDTH + IO_WIDTH - 1) / IO_WIDTH;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [DLY_WIDTH-1:0]  fill_q;
  logic [DLY_WIDTH-1:0]  delay_cur_q;
  logic [DLY_WIDTH-1:0]  delay_d;
  logic                  valid_d;
  logic                  dout_valid_q;
  logic [WIDTH-1:0]      dout_q;
  logic [WIDTH-1:0]      ram_q;
  logic [WIDTH-1:0]      tail;

  always_comb begin
    delay_d = bus.delay;
    if (bus.delay < DLY_WIDTH'(MIN_DELAY)) begin
      delay_d = DLY_WIDTH'(MIN_DELAY);
    end else if (bus.delay > DLY_WIDTH'(MAX_DELAY)) begin
      delay_d = DLY_WIDTH'(MAX_DELAY);
    end
  end

  // Read runs LATENCY ce-cycles ahead so the output register lands
  // exactly delay_cur ce-cycles after the matching write.
  assign rd_addr_d = wr_addr_q
                   - ADDR_WIDTH'(delay_cur_q)
                   + ADDR_WIDTH'(LATENCY);

  assign valid_d = (fill_q == delay_cur_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      wr_addr_q    <= '0;
      fill_q       <= '0;
      delay_cur_q  <= DLY_WIDTH'(MIN_DELAY);
      dout_valid_q <= 1'b0;
    end else begin
      if (bus.ce) begin
        wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
      end
      if (bus.delay_load) begin
        // A sample written on the load edge is the first under the new delay.
        delay_cur_q  <= delay_d;
        fill_q       <= {{(DLY_WIDTH-1){1'b0}}, bus.ce};
        state_q      <= FILL;
        dout_valid_q <= 1'b0;
      end else if (bus.ce) begin
        dout_valid_q <= valid_d;
        unique case (state_q)
          FILL: begin
            if (valid_d) begin
              state_q <= RUN;
            end else begin
              fill_q <= fill_q + DLY_WIDTH'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // The last column is cut to the remaining width, so no pad bits are stored.
  for (genvar c = 0; c < N_COL; c++) begin : g_col
    localparam int LO = c * IO_WIDTH;
    localparam int CW = ((WIDTH - LO) < IO_WIDTH) ? (WIDTH - LO) : IO_WIDTH;

    logic [CW-1:0] mem [DEPTH];
    logic [CW-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (bus.ce) begin
        mem[wr_addr_q] <= bus.din[LO +: CW];
        rd_q           <= mem[rd_addr_d];
      end
    end

    assign ram_q[LO +: CW] = rd_q;
  end

  if (LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] pipe_q;

    always_ff @(posedge clk) begin
      if (bus.ce) begin
        pipe_q <= ram_q;
      end
    end

    assign tail = pipe_q;
  end else begin : g_lat1
    assign tail = ram_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (bus.delay_load) begin
      dout_q <= '0;
    end else if (bus.ce) begin
      dout_q <= valid_d ? tail : '0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.delay_cur  = delay_cur_q;

endmodule

// File: tb/tb_bram_delay_prog.sv
// tb_bram_delay_prog: scoreboard bench for bram_delay_prog.
// Stimulus pushes written samples; a monitor pops on each valid ce edge.
module tb_bram_delay_prog;

  localparam int WIDTH     = 128;
  localparam int MAX_DELAY = 1024;
  localparam int LATENCY   = 2;
  localparam int DLY_WIDTH = $clog2(MAX_DELAY + 1);
  localparam int MIN_DELAY = LATENCY + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bram_delay_prog_if #(
    .WIDTH(WIDTH),
    .DLY_WIDTH(DLY_WIDTH)
  ) bus ();

  bram_delay_prog #(
    .WIDTH(WIDTH),
    .MAX_DELAY(MAX_DELAY),
    .LATENCY(LATENCY),
    .TARGET_DEVICE("VIRTEX5")
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int exp_dly = MIN_DELAY;
  int ramp = 0;
  int cnt = 0;
  bit mon_en = 1'b0;
  logic [WIDTH-1:0] sb [$];

  task automatic check(input string nm,
                       input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] din_of(input int k);
    logic [31:0] v;
    v = 32'(k);
    return {v ^ 32'hDEAD0000, v + 32'h1000, ~v, v};
  endfunction

  task automatic cyc(input bit c, input bit ld = 1'b0, input int dly = 0);
    @(negedge clk);
    bus.ce = c;
    bus.delay_load = ld;
    bus.delay = DLY_WIDTH'(dly);
    if (ld) sb.delete();
    if (c) begin
      ramp++;
      bus.din = din_of(ramp);
      if (rst_n) sb.push_back(bus.din);
    end else begin
      bus.din = {4{$urandom()}};
    end
  endtask

  // Monitor: pops the scoreboard on each valid ce edge.
  initial begin
    logic [WIDTH-1:0] pd;
    logic [WIDTH-1:0] e;
    logic pv;
    bit c_s;
    bit l_s;
    bit r_s;
    pd = '0;
    pv = 1'b0;
    forever begin
      @(posedge clk);
      c_s = bus.ce;
      l_s = bus.delay_load;
      r_s = rst_n;
      #1;
      if (mon_en && r_s) begin
        if (l_s) begin
          cnt = c_s ? 1 : 0;
        end else if (c_s) begin
          cnt++;
          if (bus.dout_valid) begin
            if (!pv) check("latency", WIDTH'(cnt), WIDTH'(exp_dly + 1));
            if (sb.size() == 0) begin
              n_chk++;
              $display("FAIL underflow: got %0h want none", bus.dout);
            end else begin
              e = sb.pop_front();
              check("dout", bus.dout, e);
            end
          end else begin
            check("mask", bus.dout, '0);
          end
        end else begin
          check("hold_dout", bus.dout, pd);
          check("hold_valid", WIDTH'(bus.dout_valid), WIDTH'(pv));
        end
      end else begin
        cnt = 0;
      end
      pd = bus.dout;
      pv = bus.dout_valid;
    end
  end

  initial begin
    bus.ce = 1'b0;
    bus.delay_load = 1'b0;
    bus.delay = '0;
    bus.din = '0;
    repeat (3) @(negedge clk);
    check("rst_dout", bus.dout, '0);
    check("rst_valid", WIDTH'(bus.dout_valid), '0);
    check("rst_dcur", WIDTH'(bus.delay_cur), WIDTH'(3));
    rst_n = 1'b1;
    mon_en = 1'b1;

    repeat (20) cyc(1'b1);

    exp_dly = 1000;
    cyc(1'b1, 1'b1, 1000);
    @(posedge clk);
    #1;
    check("dcur_1000", WIDTH'(bus.delay_cur), WIDTH'(1000));
    check("drop_1000", WIDTH'(bus.dout_valid), '0);
    repeat (5000) cyc(1'b1);

    exp_dly = 17;
    cyc(1'b1, 1'b1, 17);
    repeat (300) cyc(bit'($urandom_range(0, 1)));

    exp_dly = 3;
    cyc(1'b0, 1'b1, 0);
    @(posedge clk);
    #1;
    check("clamp_lo", WIDTH'(bus.delay_cur), WIDTH'(3));
    repeat (20) cyc(1'b1);

    exp_dly = MAX_DELAY;
    cyc(1'b1, 1'b1, MAX_DELAY + 5);
    @(posedge clk);
    #1;
    check("clamp_hi", WIDTH'(bus.delay_cur), WIDTH'(1024));
    repeat (1100) cyc(1'b1);

    exp_dly = 50;
    cyc(1'b1, 1'b1, 50);
    @(posedge clk);
    #1;
    check("drop_50", WIDTH'(bus.dout_valid), '0);
    check("drop_50_dout", bus.dout, '0);
    check("dcur_50", WIDTH'(bus.delay_cur), WIDTH'(50));
    repeat (80) cyc(1'b1);

    cyc(1'b1, 1'b1, 50);
    @(posedge clk);
    #1;
    check("reload_same", WIDTH'(bus.dout_valid), '0);
    repeat (60) cyc(1'b1);

    @(negedge clk);
    rst_n = 1'b0;
    bus.ce = 1'b0;
    bus.delay_load = 1'b0;
    sb.delete();
    exp_dly = MIN_DELAY;
    #1;
    check("arst_dout", bus.dout, '0);
    check("arst_valid", WIDTH'(bus.dout_valid), '0);
    check("arst_dcur", WIDTH'(bus.delay_cur), WIDTH'(3));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) cyc(1'b1);
    cyc(1'b0);
    repeat (3) @(negedge clk);
    check("pending", WIDTH'(sb.size()), WIDTH'(3));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
